// File: rtl/card_dealer.sv
// Deals cards 0..51 from one deck without repetition. A 16-bit Galois LFSR picks random
// candidates, and after MAX_TRIES misses a linear scan finds a free card.
module card_dealer #(
   parameter int SEED_WIDTH = 12,
   parameter int MAX_TRIES  = 16
) (
   input  logic                  clk_50M,
   input  logic                  i_Reset_n,
   input  logic [SEED_WIDTH-1:0] i_Seed,
   input  logic                  i_LoadSeed,
   input  logic                  i_Draw,
   output logic [5:0]            o_Card,
   output logic [3:0]            o_Rank,
   output logic [3:0]            o_Points,
   output logic                  o_Valid,
   output logic                  o_Busy,
   output logic                  o_Empty,
   output logic [5:0]            o_Remaining
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HUNT = 2'd1;
   localparam logic [1:0] SCAN = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [6:0] TRIES_LAST = 7'(MAX_TRIES - 1);

   logic [1:0]  state_q, state_d;
   logic [15:0] lfsr_q, lfsr_d, lfsr_next;
   logic [51:0] used_q, used_d;
   logic [5:0]  remaining_q, remaining_d;
   logic [6:0]  tries_q, tries_d;
   logic [5:0]  ptr_q, ptr_d;
   logic [5:0]  card_q, card_d;
   logic [3:0]  rank_q, rank_d;
   logic [3:0]  points_q, points_d;

   logic [63:0] used_ext;
   logic [5:0]  candidate;
   logic [5:0]  take_idx;
   logic [5:0]  take_mod;
   logic [3:0]  take_rank;
   logic        take;

   // Indices 52..63 read as permanently used, so one lookup also rejects out-of-deck candidates.
   assign used_ext  = {12'hFFF, used_q};
   assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
   assign candidate = lfsr_next[5:0];
   assign take_mod  = take_idx % 6'd13;
   assign take_rank = take_mod[3:0] + 4'd1;

   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      used_d      = used_q;
      remaining_d = remaining_q;
      tries_d     = tries_q;
      ptr_d       = ptr_q;
      card_d      = card_q;
      rank_d      = rank_q;
      points_d    = points_q;
      take        = 1'b0;
      take_idx    = ptr_q;

      if (i_LoadSeed) begin
         lfsr_d      = {4'hA, i_Seed};
         used_d      = '0;
         remaining_d = 6'd52;
         tries_d     = '0;
         state_d     = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_Draw && (remaining_q != 6'd0)) begin
                  state_d = HUNT;
                  tries_d = '0;
               end
            end
            HUNT: begin
               lfsr_d = lfsr_next;
               if (!used_ext[candidate]) begin
                  take     = 1'b1;
                  take_idx = candidate;
               end else if (tries_q == TRIES_LAST) begin
                  state_d = SCAN;
                  ptr_d   = (candidate < 6'd52) ? candidate : candidate - 6'd52;
               end else begin
                  tries_d = tries_q + 7'd1;
               end
            end
            SCAN: begin
               if (!used_ext[ptr_q]) begin
                  take     = 1'b1;
                  take_idx = ptr_q;
               end else begin
                  ptr_d = (ptr_q == 6'd51) ? 6'd0 : ptr_q + 6'd1;
               end
            end
            default: state_d = IDLE;
         endcase

         if (take) begin
            used_d      = used_q | (52'd1 << take_idx);
            remaining_d = remaining_q - 6'd1;
            card_d      = take_idx;
            rank_d      = take_rank;
            points_d    = (take_rank > 4'd10) ? 4'd10 : take_rank;
            state_d     = DONE;
         end
      end
   end

   always_ff @(posedge clk_50M or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q     <= IDLE;
         lfsr_q      <= 16'hACE1;
         used_q      <= '0;
         remaining_q <= 6'd52;
         tries_q     <= '0;
         ptr_q       <= '0;
         card_q      <= '0;
         rank_q      <= '0;
         points_q    <= '0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         used_q      <= used_d;
         remaining_q <= remaining_d;
         tries_q     <= tries_d;
         ptr_q       <= ptr_d;
         card_q      <= card_d;
         rank_q      <= rank_d;
         points_q    <= points_d;
      end
   end

   assign o_Card      = card_q;
   assign o_Rank      = rank_q;
   assign o_Points    = points_q;
   assign o_Valid     = (state_q == DONE);
   assign o_Busy      = (state_q != IDLE);
   assign o_Empty     = (remaining_q == 6'd0);
   assign o_Remaining = remaining_q;

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: two instances (default MAX_TRIES and MAX_TRIES=2), checked against
// a behavioural deck model that predicts each dealt card and its latency.
module tb_card_dealer;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic        rst_n;
   logic [11:0] seed;
   logic        draw1, load1, draw2, load2;
   logic [5:0]  card1, rem1, card2, rem2;
   logic [3:0]  rank1, pts1, rank2, pts2;
   logic        valid1, busy1, empty1, valid2, busy2, empty2;

   card_dealer #(.SEED_WIDTH(12), .MAX_TRIES(16)) dut1 (
      .clk_50M(clk), .i_Reset_n(rst_n), .i_Seed(seed), .i_LoadSeed(load1), .i_Draw(draw1),
      .o_Card(card1), .o_Rank(rank1), .o_Points(pts1), .o_Valid(valid1), .o_Busy(busy1),
      .o_Empty(empty1), .o_Remaining(rem1)
   );

   card_dealer #(.SEED_WIDTH(12), .MAX_TRIES(2)) dut2 (
      .clk_50M(clk), .i_Reset_n(rst_n), .i_Seed(seed), .i_LoadSeed(load2), .i_Draw(draw2),
      .o_Card(card2), .o_Rank(rank2), .o_Points(pts2), .o_Valid(valid2), .o_Busy(busy2),
      .o_Empty(empty2), .o_Remaining(rem2)
   );

   int          sel;
   logic [5:0]  card, rem;
   logic [3:0]  rank, pts;
   logic        valid, busy, empty;

   always_comb begin
      card  = (sel == 0) ? card1  : card2;
      rem   = (sel == 0) ? rem1   : rem2;
      rank  = (sel == 0) ? rank1  : rank2;
      pts   = (sel == 0) ? pts1   : pts2;
      valid = (sel == 0) ? valid1 : valid2;
      busy  = (sel == 0) ? busy1  : busy2;
      empty = (sel == 0) ? empty1 : empty2;
   end

   int total = 0;
   int bad   = 0;

   logic [15:0] mLfsr;
   bit          mUsed[52];
   int          mRemaining;
   int          lastCard[2];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic modelReseed(input logic [11:0] s);
      mLfsr = {4'hA, s};
      for (int i = 0; i < 52; i++) mUsed[i] = 1'b0;
      mRemaining = 52;
   endtask

   // Random picks first, then a wrapping sweep from the last candidate; cycles = cards examined.
   task automatic modelDraw(input int maxTries, output int c, output int cycles);
      int  cand;
      int  ptr;
      bit  found;
      found  = 1'b0;
      cycles = 0;
      cand   = 0;
      c      = 0;
      for (int t = 0; t < maxTries && !found; t++) begin
         mLfsr = {1'b0, mLfsr[15:1]} ^ (mLfsr[0] ? 16'hB400 : 16'h0000);
         cycles++;
         cand = int'(mLfsr[5:0]);
         if (cand < 52 && !mUsed[cand]) begin
            found = 1'b1;
            c     = cand;
         end
      end
      if (!found) begin
         ptr = (cand < 52) ? cand : cand - 52;
         while (!found) begin
            cycles++;
            if (!mUsed[ptr]) begin
               found = 1'b1;
               c     = ptr;
            end else begin
               ptr = (ptr + 1) % 52;
            end
         end
      end
      mUsed[c] = 1'b1;
      mRemaining--;
   endtask

   task automatic applyStimulus(input logic d, input logic l, input logic [11:0] s);
      if (sel == 0) begin
         draw1 = d;
         load1 = l;
      end else begin
         draw2 = d;
         load2 = l;
      end
      seed = s;
      @(negedge clk);
      draw1 = 1'b0;
      load1 = 1'b0;
      draw2 = 1'b0;
      load2 = 1'b0;
   endtask

   task automatic doLoad(input logic [11:0] s);
      applyStimulus(1'b0, 1'b1, s);
      modelReseed(s);
      checkOutput("load_busy", busy, 0);
      checkOutput("load_valid", valid, 0);
      checkOutput("load_remaining", rem, 52);
      checkOutput("load_empty", empty, 0);
      checkOutput("load_card_held", card, lastCard[sel]);
   endtask

   task automatic doDraw(input bit spam, output int gotCard, output int gotPts);
      int expCard, expCycles, k, expRank, expPts;
      modelDraw((sel == 0) ? 16 : 2, expCard, expCycles);
      expRank = expCard % 13 + 1;
      expPts  = (expRank > 10) ? 10 : expRank;
      applyStimulus(1'b1, 1'b0, 12'h000);
      k = 0;
      while (valid !== 1'b1 && k < 200) begin
         applyStimulus(spam, 1'b0, 12'h000);
         k++;
      end
      checkOutput("draw_valid", valid, 1);
      checkOutput("draw_latency", k, expCycles);
      checkOutput("draw_card", card, expCard);
      checkOutput("draw_rank", rank, expRank);
      checkOutput("draw_points", pts, expPts);
      checkOutput("draw_remaining", rem, mRemaining);
      checkOutput("draw_empty", empty, (mRemaining == 0) ? 1 : 0);
      gotCard = int'(card);
      gotPts  = int'(pts);
      lastCard[sel] = expCard;
      applyStimulus(spam, 1'b0, 12'h000);
      checkOutput("after_valid", valid, 0);
      checkOutput("after_busy", busy, 0);
      checkOutput("after_card_held", card, expCard);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int  c, p, cy, distinct, sumPts, idleValids, foundSeed;
      bit  seen[52];
      bit  found;

      sel   = 0;
      rst_n = 1'b0;
      seed  = 12'h000;
      draw1 = 1'b0;
      load1 = 1'b0;
      draw2 = 1'b0;
      load2 = 1'b0;
      lastCard[0] = 0;
      lastCard[1] = 0;
      repeat (2) @(negedge clk);
      checkOutput("rst_valid", valid1, 0);
      checkOutput("rst_busy", busy1, 0);
      checkOutput("rst_empty", empty1, 0);
      checkOutput("rst_remaining", rem1, 52);
      checkOutput("rst_card", card1, 0);
      checkOutput("rst_rank", rank1, 0);
      checkOutput("rst_points", pts1, 0);
      checkOutput("rst2_remaining", rem2, 52);
      checkOutput("rst2_busy", busy2, 0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_remaining", rem1, 52);

      // Known seed: the first two deals are fixed by the LFSR sequence.
      doLoad(12'h000);
      doDraw(1'b0, c, p);
      checkOutput("seed0_first_card", c, 0);
      doDraw(1'b0, c, p);
      checkOutput("seed0_second_card", c, 32);
      checkOutput("seed0_second_rank", rank1, 7);

      // Reseed while a draw is in flight: aborted, no strobe, deck restored.
      applyStimulus(1'b1, 1'b0, 12'h000);
      checkOutput("abort_busy_before", busy1, 1);
      seed = 12'($urandom_range(0, 4095));
      applyStimulus(1'b0, 1'b1, seed);
      modelReseed(seed);
      checkOutput("abort_busy", busy1, 0);
      checkOutput("abort_valid", valid1, 0);
      checkOutput("abort_remaining", rem1, 52);
      checkOutput("abort_card_held", card1, 32);
      idleValids = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 12'h000);
         if (valid1 === 1'b1) idleValids++;
      end
      checkOutput("abort_no_valid", idleValids, 0);

      // Full deck, with extra draw pulses during some busy periods.
      for (int i = 0; i < 52; i++) seen[i] = 1'b0;
      distinct = 0;
      sumPts   = 0;
      for (int i = 0; i < 52; i++) begin
         doDraw((i % 3) == 0, c, p);
         if (c < 52 && !seen[c]) begin
            seen[c] = 1'b1;
            distinct++;
         end
         sumPts += p;
      end
      checkOutput("deck_distinct", distinct, 52);
      checkOutput("deck_points_sum", sumPts, 340);
      checkOutput("deck_empty", empty1, 1);
      checkOutput("deck_remaining", rem1, 0);

      applyStimulus(1'b1, 1'b0, 12'h000);
      checkOutput("empty_draw_busy", busy1, 0);
      idleValids = 0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 12'h000);
         if (valid1 === 1'b1 || busy1 === 1'b1) idleValids++;
      end
      checkOutput("empty_draw_ignored", idleValids, 0);

      doLoad(12'($urandom_range(0, 4095)));
      for (int i = 0; i < 3; i++) doDraw(1'b1, c, p);

      // Find a seed whose final deal with MAX_TRIES=2 is card 51, reached by the sweep.
      found     = 1'b0;
      foundSeed = 0;
      for (int s = 0; s < 4096 && !found; s++) begin
         modelReseed(12'(s));
         for (int i = 0; i < 52; i++) modelDraw(2, c, cy);
         if (c == 51) begin
            found     = 1'b1;
            foundSeed = s;
         end
      end
      $display("[TB] MAX_TRIES=2 seed search found=%0d seed=%0d", found, foundSeed);

      sel = 1;
      #1;
      doLoad(12'(foundSeed));
      for (int i = 0; i < 52; i++) doDraw((i % 4) == 1, c, p);
      if (found) begin
         checkOutput("scan_last_card", card2, 51);
         checkOutput("scan_last_rank", rank2, 13);
         checkOutput("scan_last_points", pts2, 10);
      end
      checkOutput("scan_empty", empty2, 1);

      // Asynchronous reset during a draw.
      sel = 0;
      #1;
      applyStimulus(1'b1, 1'b0, 12'h000);
      checkOutput("mid_rst_busy_before", busy1, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_busy", busy1, 0);
      checkOutput("mid_rst_valid", valid1, 0);
      checkOutput("mid_rst_card", card1, 0);
      checkOutput("mid_rst_remaining", rem1, 52);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("mid_rst_idle", busy1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
